// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: pipelined imem fetch with credit-limited instruction FIFO; RV32I_FETCH_BYPASS_EN adds 0-cycle empty-FIFO bypass
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] imem_add_o,
  output logic        imem_re_o,
  input  logic [31:0] imem_data_i,
  input  logic        imem_valid_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] fetch_pc_q, resp_pc_q;
  logic [CW-1:0] out_q, drop_q, wp_q, rp_q, count;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pc_q [FIFO_DEPTH];
  logic resp, keep, byp, push, pop, empty;
  assign count = wp_q - rp_q;
  assign empty = count == '0;
  assign resp = imem_valid_i && out_q != '0;
  assign keep = resp && drop_q == '0;
  assign imem_add_o = fetch_pc_q;
  assign imem_re_o = !reset_i && !redirect_i && out_q < CW'(MAX_OUTSTANDING) &&
                     count + out_q - drop_q < CW'(FIFO_DEPTH);
`ifdef RV32I_FETCH_BYPASS_EN
  assign byp = !reset_i && !redirect_i && empty && keep;
`else
  assign byp = 1'b0;
`endif
  assign instr_valid_o = !reset_i && (!empty || byp);
  assign instr_o = !instr_valid_o ? NOP : byp ? imem_data_i : data_q[rp_q[AW-1:0]];
  assign instr_pc_o = byp ? resp_pc_q : pc_q[rp_q[AW-1:0]];
  assign pop = instr_valid_o && instr_ready_i && !byp;
  assign push = keep && !redirect_i && !(byp && instr_ready_i);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      out_q <= out_q + CW'(imem_re_o) - CW'(resp);
      if (redirect_i) begin
        fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
        resp_pc_q <= {redirect_pc_i[31:2], 2'b00};
        drop_q <= out_q - CW'(resp);
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (imem_re_o) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (resp && drop_q != '0) drop_q <= drop_q - 1'b1;
        if (keep) resp_pc_q <= resp_pc_q + 32'd4;
        if (push) wp_q <= wp_q + 1'b1;
        if (pop) rp_q <= rp_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      data_q[wp_q[AW-1:0]] <= imem_data_i;
      pc_q[wp_q[AW-1:0]] <= resp_pc_q;
    end
  end
  assert property (@(posedge clk_i) disable iff (reset_i) imem_valid_i |-> out_q != '0);
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: queue-based model of in-flight requests and buffered instructions checked every cycle
module tb_rv32i_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk_i = 1'b0;
  logic reset_i, imem_re_o, imem_valid_i, redirect_i, instr_valid_o, instr_ready_i;
  logic [31:0] imem_add_o, imem_data_i, redirect_pc_i, instr_o, instr_pc_o;
  typedef struct { logic [31:0] a; int due; } mreq_t;
  typedef struct { logic [31:0] a; bit stale; } inf_t;
  typedef struct { logic [31:0] d; logic [31:0] p; } ent_t;
  mreq_t mem_q[$];
  inf_t inf_q[$];
  ent_t fifo_q[$];
  logic [31:0] acc_pc[$], acc_d[$];
  int acc_cyc[$];
  logic [31:0] m_fetch;
  logic [31:0] s_add, s_instr, s_pc;
  logic s_re, s_valid;
  int cyc = 0, lat = 1, tests = 0, fails = 0, re_cnt;
  bit ok;

  rv32i_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .imem_add_o(imem_add_o), .imem_re_o(imem_re_o),
    .imem_data_i(imem_data_i), .imem_valid_i(imem_valid_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic step();
    logic resp, e_valid, e_re, stale0;
    bit byp;
    int live;
    inf_t f;
    resp = !reset_i && mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_valid_i = resp;
    imem_data_i = resp ? memf(mem_q[0].a) : 32'hDEAD_BEEF;
    #1;
    s_add = imem_add_o; s_re = imem_re_o; s_valid = instr_valid_o; s_instr = instr_o; s_pc = instr_pc_o;
    stale0 = inf_q.size() > 0 ? inf_q[0].stale : 1'b1;
    byp = 0;
`ifdef RV32I_FETCH_BYPASS_EN
    byp = fifo_q.size() == 0 && resp && !stale0 && !redirect_i;
`endif
    live = 0;
    foreach (inf_q[i]) if (!inf_q[i].stale) live++;
    e_valid = fifo_q.size() > 0 || byp;
    e_re = !redirect_i && inf_q.size() < MAXO && fifo_q.size() + live < DEPTH;
    if (reset_i) begin
      chk("rst_re", 32'(s_re), 32'd0);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_instr", s_instr, NOP);
    end else begin
      chk("re", 32'(s_re), 32'(e_re));
      chk("add", s_add, m_fetch);
      chk("valid", 32'(s_valid), 32'(e_valid));
      if (e_valid) begin
        chk("instr", s_instr, byp ? imem_data_i : fifo_q[0].d);
        chk("instr_pc", s_pc, byp ? inf_q[0].a : fifo_q[0].p);
      end else chk("instr_nop", s_instr, NOP);
      if (s_valid && instr_ready_i) begin
        acc_pc.push_back(s_pc); acc_d.push_back(s_instr); acc_cyc.push_back(cyc);
      end
    end
    @(posedge clk_i);
    if (reset_i) begin
      mem_q = {}; inf_q = {}; fifo_q = {}; m_fetch = 32'h0; cyc = 0;
    end else begin
      if (redirect_i) begin
        fifo_q = {};
        foreach (inf_q[i]) begin f = inf_q[i]; f.stale = 1; inf_q[i] = f; end
        if (resp && inf_q.size() > 0) void'(inf_q.pop_front());
        m_fetch = {redirect_pc_i[31:2], 2'b00};
      end else begin
        if (e_valid && instr_ready_i && !byp && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (resp && inf_q.size() > 0) begin
          f = inf_q.pop_front();
          if (!f.stale && !(byp && instr_ready_i)) fifo_q.push_back('{imem_data_i, f.a});
        end
        if (e_re) begin inf_q.push_back('{m_fetch, 0}); m_fetch = m_fetch + 32'd4; end
      end
      if (resp) void'(mem_q.pop_front());
      if (s_re) mem_q.push_back('{s_add, cyc + lat});
      cyc++;
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1; redirect_i = 0; instr_ready_i = 1;
    repeat (3) step();
    reset_i = 0;
    acc_pc = {}; acc_d = {}; acc_cyc = {};
  endtask

  initial begin
    reset_i = 1; imem_valid_i = 0; imem_data_i = 0; redirect_i = 0;
    redirect_pc_i = 0; instr_ready_i = 1;
    @(negedge clk_i); #1;
    // free-running, 1-cycle memory
    lat = 1;
    do_reset();
    step();
    chk("reset_add", s_add, 32'h0);
    repeat (11) step();
    chk("seq0", acc_pc[0], 32'h0);
    chk("seq1", acc_pc[1], 32'h4);
    chk("seq2", acc_pc[2], 32'h8);
    chk("seq3", acc_pc[3], 32'hC);
    chk("data0", acc_d[0], 32'h5A5A_0000);
`ifdef RV32I_FETCH_BYPASS_EN
    chk("first_acc_cyc", 32'(acc_cyc[0]), 32'd1);
    chk("acc_count", 32'(acc_pc.size()), 32'd11);
`else
    chk("first_acc_cyc", 32'(acc_cyc[0]), 32'd2);
    chk("acc_count", 32'(acc_pc.size()), 32'd10);
`endif
    // backpressure
    do_reset();
    instr_ready_i = 0;
    re_cnt = 0;
    repeat (10) begin step(); re_cnt += 32'(s_re); end
    chk("stall_issues", 32'(re_cnt), 32'd4);
    chk("stall_head_pc", s_pc, 32'h0);
    chk("stall_head_valid", 32'(s_valid), 32'd1);
    instr_ready_i = 1;
    repeat (14) step();
    chk("release_count", 32'(acc_pc.size()), 32'd14);
    ok = 1;
    foreach (acc_pc[i]) if (acc_pc[i] !== 32'(4 * i)) ok = 0;
    chk("release_seq", 32'(ok), 32'd1);
    // redirect with two in flight
    lat = 3;
    do_reset();
    repeat (2) step();
    acc_pc = {}; acc_d = {};
    redirect_i = 1; redirect_pc_i = 32'h100;
    step();
    chk("redir_no_issue", 32'(s_re), 32'd0);
    redirect_i = 0;
    step();
    chk("redir_empty", 32'(s_valid), 32'd0);
    repeat (10) step();
    chk("redir_pc", acc_pc[0], 32'h100);
    chk("redir_data", acc_d[0], 32'h5A5A_0100);
    // redirect coinciding with responses, back to back
    lat = 2;
    do_reset();
    repeat (2) step();
    acc_pc = {};
    redirect_i = 1; redirect_pc_i = 32'h200;
    step();
    redirect_pc_i = 32'h300;
    step();
    redirect_i = 0;
    repeat (10) step();
    chk("b2b_pc0", acc_pc[0], 32'h300);
    chk("b2b_pc1", acc_pc[1], 32'h304);
    // unaligned redirect and PC wrap
    lat = 1;
    do_reset();
    redirect_i = 1; redirect_pc_i = 32'h1006;
    step();
    redirect_i = 0;
    step();
    chk("unaligned_add", s_add, 32'h1004);
    chk("unaligned_re", 32'(s_re), 32'd1);
    acc_pc = {}; acc_d = {};
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 0;
    step();
    chk("wrap_add0", s_add, 32'hFFFF_FFFC);
    chk("wrap_re", 32'(s_re), 32'd1);
    step();
    chk("wrap_add1", s_add, 32'h0);
    repeat (4) step();
    chk("wrap_pc0", acc_pc[0], 32'hFFFF_FFFC);
    chk("wrap_data0", acc_d[0], 32'hA5A5_FFFC);
    chk("wrap_pc1", acc_pc[1], 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
